ysyx_24100005_regfile_unit: RTL and testbench

YSYX_24100005_REGFILE_UNIT -- requirements
Module: ysyx_24100005_regfile_unit

---
 rtl/ysyx_24100005_regfile_unit_if.sv | 35 +++
 rtl/ysyx_24100005_regfile_unit.sv | 52 +++++
 tb/tb_ysyx_24100005_regfile_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_regfile_unit_if.sv
// Bundles the register-file, PC and lookup-mux signals of ysyx_24100005_regfile_unit.
// The master side drives the requests; the slave side is the unit itself.
interface ysyx_24100005_regfile_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_KEY     = 4,
  parameter int KEY_LEN    = 7
);
  logic                                     rf_wen;
  logic [ADDR_WIDTH-1:0]                    rf_waddr;
  logic [DATA_WIDTH-1:0]                    rf_wdata;
  logic [ADDR_WIDTH-1:0]                    rs1addr;
  logic [ADDR_WIDTH-1:0]                    rs2addr;
  logic [DATA_WIDTH-1:0]                    rs1data;
  logic [DATA_WIDTH-1:0]                    rs2data;
  logic                                     pc_wen;
  logic [DATA_WIDTH-1:0]                    pc_din;
  logic [DATA_WIDTH-1:0]                    pc_dout;
  logic [KEY_LEN-1:0]                       mux_key;
  logic [DATA_WIDTH-1:0]                    mux_default;
  logic [NR_KEY*(KEY_LEN+DATA_WIDTH)-1:0]   mux_lut;
  logic [DATA_WIDTH-1:0]                    mux_out;

  modport master (
    output rf_wen, rf_waddr, rf_wdata, rs1addr, rs2addr,
    output pc_wen, pc_din, mux_key, mux_default, mux_lut,
    input  rs1data, rs2data, pc_dout, mux_out
  );

  modport slave (
    input  rf_wen, rf_waddr, rf_wdata, rs1addr, rs2addr,
    input  pc_wen, pc_din, mux_key, mux_default, mux_lut,
    output rs1data, rs2data, pc_dout, mux_out
  );
endinterface

// File: rtl/ysyx_24100005_regfile_unit.sv
// Register file (x0 hardwired to zero), PC register and priority key lookup mux.
// The three functions are independent; only the register file and PC are clocked.
module ysyx_24100005_regfile_unit #(
  parameter int                   ADDR_WIDTH = 5,
  parameter int                   DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = 32'h8000_0000,
  parameter int                   NR_KEY     = 4,
  parameter int                   KEY_LEN    = 7
) (
  input  logic clk,
  input  logic rst,
  ysyx_24100005_regfile_unit_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PAIR  = KEY_LEN + DATA_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] pc_q;

  // NOTE: every entry must be cleared by reset, so the array is reset in a loop;
  // this keeps it out of RAM macros, which cannot clear all words in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (bus.rf_wen && bus.rf_waddr != '0) begin
      regs[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst)           pc_q <= RESET_VAL;
    else if (bus.pc_wen) pc_q <= bus.pc_din;
  end

  // Reads see the array contents before the edge; there is deliberately no bypass.
  assign bus.rs1data = (bus.rs1addr == '0) ? '0 : regs[bus.rs1addr];
  assign bus.rs2data = (bus.rs2addr == '0) ? '0 : regs[bus.rs2addr];
  assign bus.pc_dout = pc_q;

  // Entry 0 sits in the most-significant slot. Scanning from the last entry
  // down lets the lowest-index match overwrite the others.
  always_comb begin
    // NOTE: assigning the default first means every path drives mux_out, so no latch.
    bus.mux_out = bus.mux_default;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (bus.mux_lut[(NR_KEY-1-i)*PAIR + DATA_WIDTH +: KEY_LEN] == bus.mux_key)
        bus.mux_out = bus.mux_lut[(NR_KEY-1-i)*PAIR +: DATA_WIDTH];
    end
  end
endmodule

// File: tb/tb_ysyx_24100005_regfile_unit.sv
// Directed and random checks of ysyx_24100005_regfile_unit against an array/queue
// reference model of the register file, PC and first-match lookup.
module tb_ysyx_24100005_regfile_unit;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NK = 4;
  localparam int KL = 7;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ysyx_24100005_regfile_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                                  .NR_KEY(NK), .KEY_LEN(KL)) bus ();

  ysyx_24100005_regfile_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_VAL(RST_PC),
                               .NR_KEY(NK), .KEY_LEN(KL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] ref_rf [32];
  logic [31:0] ref_pc;
  logic [6:0]  lut_key  [NK];
  logic [31:0] lut_data [NK];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    return (a == 0) ? 32'h0 : ref_rf[a];
  endfunction

  function automatic logic [31:0] ref_mux(input logic [6:0] key, input logic [31:0] dflt);
    for (int i = 0; i < NK; i++)
      if (lut_key[i] == key) return lut_data[i];
    return dflt;
  endfunction

  task automatic load_lut();
    for (int i = 0; i < NK; i++)
      bus.mux_lut[(NK-1-i)*(KL+DW) +: (KL+DW)] = {lut_key[i], lut_data[i]};
  endtask

  // Advance one clock; the model applies the spec's edge rules to the driven inputs.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      foreach (ref_rf[i]) ref_rf[i] = 32'h0;
      ref_pc = RST_PC;
    end else begin
      if (bus.rf_wen) ref_rf[bus.rf_waddr] = bus.rf_wdata;
      if (bus.pc_wen) ref_pc = bus.pc_din;
    end
    #1;
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rs1"}, bus.rs1data, ref_read(bus.rs1addr));
    check({tag, "_rs2"}, bus.rs2data, ref_read(bus.rs2addr));
  endtask

  logic [6:0] key_pool [5];

  initial begin
    key_pool = '{7'h13, 7'h17, 7'h6F, 7'h67, 7'h03};
    foreach (ref_rf[i]) ref_rf[i] = 32'hx;
    ref_pc = 32'hx;
    rst = 1'b0;
    bus.rf_wen = 1'b0; bus.rf_waddr = '0; bus.rf_wdata = '0;
    bus.rs1addr = '0;  bus.rs2addr = '0;
    bus.pc_wen = 1'b0; bus.pc_din = '0;
    bus.mux_key = '0;  bus.mux_default = '0; bus.mux_lut = '0;
    #2;
    tick();

    // Reset state: PC at reset vector, every entry reads zero.
    rst = 1'b1;
    #1;
    check("reset_pc", bus.pc_dout, 32'h8000_0000);
    for (int a = 0; a < 32; a++) begin
      bus.rs1addr = 5'(a); bus.rs2addr = 5'(31 - a);
      #1;
      check("reset_rs1", bus.rs1data, 32'h0);
      check("reset_rs2", bus.rs2data, 32'h0);
    end

    // Write x5: old value before the edge, new value after, on both ports.
    bus.rf_wen = 1'b1; bus.rf_waddr = 5'd5; bus.rf_wdata = 32'hDEAD_BEEF;
    bus.rs1addr = 5'd5; bus.rs2addr = 5'd5;
    #1;
    check("x5_pre_edge", bus.rs1data, 32'h0);
    tick();
    bus.rf_wen = 1'b0;
    check("x5_rs1", bus.rs1data, 32'hDEAD_BEEF);
    check("x5_rs2", bus.rs2data, 32'hDEAD_BEEF);

    // Write to x0 is dropped.
    bus.rf_wen = 1'b1; bus.rf_waddr = 5'd0; bus.rf_wdata = 32'h1234_5678;
    tick();
    bus.rf_wen = 1'b0; bus.rs1addr = 5'd0;
    #1;
    check("x0_zero", bus.rs1data, 32'h0);

    // Top address written normally.
    bus.rf_wen = 1'b1; bus.rf_waddr = 5'd31; bus.rf_wdata = 32'hA5A5_0F0F;
    tick();
    bus.rf_wen = 1'b0; bus.rs2addr = 5'd31;
    #1;
    check("x31_write", bus.rs2data, 32'hA5A5_0F0F);

    // PC load, hold, and reset overriding a load.
    bus.pc_wen = 1'b1; bus.pc_din = 32'h8000_0004;
    tick();
    check("pc_load", bus.pc_dout, 32'h8000_0004);
    bus.pc_wen = 1'b0; bus.pc_din = 32'h0;
    tick();
    check("pc_hold", bus.pc_dout, 32'h8000_0004);
    rst = 1'b0; bus.pc_wen = 1'b1; bus.pc_din = 32'h1111_2222;
    tick();
    check("pc_rst_over_load", bus.pc_dout, 32'h8000_0000);
    bus.rs1addr = 5'd5;
    #1;
    check("rf_cleared_by_rst", bus.rs1data, 32'h0);
    rst = 1'b1; bus.pc_wen = 1'b0;

    // Reset beats a simultaneous write to x31.
    bus.rf_wen = 1'b1; bus.rf_waddr = 5'd31; bus.rf_wdata = 32'hFFFF_FFFF; rst = 1'b0;
    tick();
    rst = 1'b1; bus.rf_wen = 1'b0; bus.rs1addr = 5'd31;
    #1;
    check("x31_rst_wins", bus.rs1data, 32'h0);

    // Lookup mux: hit, miss, duplicate key, and independence from reset.
    lut_key  = '{7'h13, 7'h17, 7'h6F, 7'h67};
    lut_data = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    load_lut();
    bus.mux_default = 32'h0;
    bus.mux_key = 7'h17;
    #1;
    check("mux_hit", bus.mux_out, 32'hBBBB_0002);
    bus.mux_key = 7'h03;
    #1;
    check("mux_miss", bus.mux_out, 32'h0);
    lut_key[2] = 7'h13;
    load_lut();
    bus.mux_key = 7'h13;
    #1;
    check("mux_dup_first", bus.mux_out, 32'hAAAA_0001);
    bus.mux_key = 7'h55; bus.mux_default = 32'hCAFE_F00D; rst = 1'b0;
    #1;
    check("mux_default_in_rst", bus.mux_out, 32'hCAFE_F00D);
    tick();
    rst = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst             = ($urandom_range(0, 19) != 0);
      bus.rf_wen      = $urandom_range(0, 1) == 1;
      bus.rf_waddr    = 5'($urandom_range(0, 31));
      bus.rf_wdata    = $urandom;
      bus.rs1addr     = ($urandom_range(0, 3) == 0) ? bus.rf_waddr : 5'($urandom_range(0, 31));
      bus.rs2addr     = 5'($urandom_range(0, 31));
      bus.pc_wen      = $urandom_range(0, 1) == 1;
      bus.pc_din      = $urandom;
      for (int i = 0; i < NK; i++) begin
        lut_key[i]  = key_pool[$urandom_range(0, 4)];
        lut_data[i] = $urandom;
      end
      load_lut();
      bus.mux_key     = key_pool[$urandom_range(0, 4)];
      bus.mux_default = $urandom;
      #1;
      check("rnd_pre", bus.rs1data, ref_read(bus.rs1addr));
      check("rnd_pc_pre", bus.pc_dout, ref_pc);
      check("rnd_mux", bus.mux_out, ref_mux(bus.mux_key, bus.mux_default));
      tick();
      check_reads("rnd_post");
      check("rnd_pc_post", bus.pc_dout, ref_pc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
